// File: rtl/axi4_lite_regfile_slave.sv
// rtl/axi4_lite_regfile_slave.sv - AXI4-Lite register file slave with byte strobes, status registers and error responses
module axi4_lite_regfile_slave #(
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   DATA_WIDTH = 32,
  parameter int                   NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int NSTRB    = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NSTRB);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SPAN = ADDR_WIDTH'(NUM_REGS * NSTRB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} w_state_e;
  typedef enum logic {R_ADDR, R_DATA} r_state_e;

  w_state_e                w_state_q;
  r_state_e                r_state_q;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   hw_stat [NUM_REGS];

  logic                    awready_q, wready_q, bvalid_q;
  logic [1:0]              bresp_q;
  logic                    aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NSTRB-1:0]        wstrb_q;

  logic                    arready_q, rvalid_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    aw_hs, w_hs, commit, wr_err;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NSTRB-1:0]        wr_strb;
  logic [IDX_W-1:0]        wr_idx;
  logic                    ar_hs, rd_err;
  logic [IDX_W-1:0]        rd_idx;
  logic [DATA_WIDTH-1:0]   rd_val;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (a >= ADDR_SPAN) || (a[ADDR_LSB-1:0] != '0);
  endfunction

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign hw_stat[g] = hw_status_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_q[g];
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  // A handshake on this edge stands in for a value not yet latched.
  always_comb begin
    aw_hs   = AWVALID && awready_q;
    w_hs    = WVALID && wready_q;
    commit  = (w_state_q == W_COLLECT) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    wr_addr = aw_held_q ? awaddr_q : AWADDR;
    wr_data = w_held_q ? wdata_q : WDATA;
    wr_strb = w_held_q ? wstrb_q : WSTRB;
    wr_idx  = wr_addr[ADDR_LSB +: IDX_W];
    wr_err  = addr_err(wr_addr) || RO_MASK[wr_idx];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_COLLECT;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      case (w_state_q)
        W_COLLECT: begin
          if (commit) begin
            if (!wr_err) begin
              for (int k = 0; k < NSTRB; k++) begin
                if (wr_strb[k]) regs_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
              end
            end
            bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            bvalid_q  <= 1'b1;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            w_state_q <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held_q <= 1'b1;
              awaddr_q  <= AWADDR;
              awready_q <= 1'b0;
            end
            if (w_hs) begin
              w_held_q <= 1'b1;
              wdata_q  <= WDATA;
              wstrb_q  <= WSTRB;
              wready_q <= 1'b0;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_COLLECT;
          end
        end
        default: w_state_q <= W_COLLECT;
      endcase
    end
  end

  // regs_q is sampled before any same-edge write lands, so a colliding read sees the old value.
  always_comb begin
    ar_hs  = ARVALID && arready_q;
    rd_idx = ARADDR[ADDR_LSB +: IDX_W];
    rd_err = addr_err(ARADDR);
    if (rd_err)                rd_val = '0;
    else if (RO_MASK[rd_idx])  rd_val = hw_stat[rd_idx];
    else                       rd_val = regs_q[rd_idx];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_ADDR;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_ADDR: begin
          if (ar_hs) begin
            rdata_q   <= rd_val;
            rresp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_ADDR;
          end
        end
        default: r_state_q <= R_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// tb/tb_axi4_lite_regfile_slave.sv - directed self-checking bench for axi4_lite_regfile_slave
module tb_axi4_lite_regfile_slave;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h8000;
  localparam logic [31:0] STAT15 = 32'hA5A5_0F0F;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [31:0]   AWADDR = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [31:0]   WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b0;
  logic [31:0]   ARADDR = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b0;
  logic [NR*32-1:0] hw_status_i;
  logic [NR*32-1:0] regs_o;

  int errors = 0;
  int checks = 0;

  axi4_lite_regfile_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .RO_MASK(RO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .hw_status_i(hw_status_i), .regs_o(regs_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output bit ok);
    bit aw_pend, w_pend, aw_fire, w_fire;
    int n;
    @(negedge ACLK);
    AWADDR = addr; AWVALID = 1'b1; WDATA = data; WSTRB = strb; WVALID = 1'b1;
    aw_pend = 1; w_pend = 1; n = 0;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      @(negedge ACLK); n++;
      if (aw_fire) begin AWVALID = 1'b0; aw_pend = 0; end
      if (w_fire)  begin WVALID = 1'b0;  w_pend = 0;  end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    while (!BVALID && n < 40) begin @(negedge ACLK); n++; end
    ok = (BVALID === 1'b1);
    resp = BRESP;
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output bit ok);
    bit fire;
    int n;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1'b1; n = 0;
    while (ARVALID && n < 20) begin
      fire = ARREADY;
      @(negedge ACLK); n++;
      if (fire) ARVALID = 1'b0;
    end
    ARVALID = 1'b0;
    while (!RVALID && n < 40) begin @(negedge ACLK); n++; end
    ok = (RVALID === 1'b1);
    data = RDATA;
    resp = RRESP;
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, exp;
    logic [1:0] r;
    bit ok;
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
      errors++; $display("FAIL reset_handshake: got %b expected 11100", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    checks++;
    if (BRESP !== 2'b00 || RRESP !== 2'b00 || RDATA !== 32'h0) begin
      errors++; $display("FAIL reset_resp: got bresp=%b rresp=%b rdata=%h expected 00 00 0", BRESP, RRESP, RDATA);
    end
    checks++;
    if (regs_o !== '0) begin
      errors++; $display("FAIL reset_regs_o: got %h expected 0", regs_o);
    end
    for (int i = 0; i < NR; i++) begin
      do_read(32'(i * 4), d, r, ok);
      exp = (i == 15) ? STAT15 : 32'h0;
      checks++;
      if (!ok || d !== exp || r !== 2'b00) begin
        errors++; $display("FAIL reset_read_%0d: got ok=%0d data=%h resp=%b expected 1 %h 00", i, ok, d, r, exp);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    @(negedge ACLK);
    AWADDR = 32'h08; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      errors++; $display("FAIL same_cycle_bresp: got bvalid=%b bresp=%b expected 1 00", BVALID, BRESP);
    end
    checks++;
    if (regs_o[2*32 +: 32] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL same_cycle_regs_o: got %h expected deadbeef", regs_o[2*32 +: 32]);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      errors++; $display("FAIL same_cycle_release: got bvalid=%b awready=%b wready=%b expected 0 1 1", BVALID, AWREADY, WREADY);
    end
    do_read(32'h08, d, r, ok);
    checks++;
    if (!ok || d !== 32'hDEADBEEF || r !== 2'b00) begin
      errors++; $display("FAIL same_cycle_read: got ok=%0d data=%h resp=%b expected 1 deadbeef 00", ok, d, r);
    end
  endtask

  task automatic test_w_first();
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    do_write(32'h04, 32'hFFFF_FFFF, 4'hF, r, ok);
    @(negedge ACLK);
    WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    checks++;
    if (WREADY !== 1'b0 || AWREADY !== 1'b1 || BVALID !== 1'b0) begin
      errors++; $display("FAIL w_first_hold: got wready=%b awready=%b bvalid=%b expected 0 1 0", WREADY, AWREADY, BVALID);
    end
    repeat (2) @(negedge ACLK);
    AWADDR = 32'h04; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      errors++; $display("FAIL w_first_bresp: got bvalid=%b bresp=%b expected 1 00", BVALID, BRESP);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    do_read(32'h04, d, r, ok);
    checks++;
    if (!ok || d !== 32'hFF22FF44 || r !== 2'b00) begin
      errors++; $display("FAIL w_first_read: got ok=%0d data=%h resp=%b expected 1 ff22ff44 00", ok, d, r);
    end
  endtask

  task automatic test_errors();
    logic [NR*32-1:0] snap;
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    logic [31:0] bad_addr [3];
    bad_addr[0] = 32'h40; bad_addr[1] = 32'h06; bad_addr[2] = 32'h3C;
    snap = regs_o;
    for (int i = 0; i < 3; i++) begin
      do_write(bad_addr[i], 32'hFFFF_FFFF, 4'hF, r, ok);
      checks++;
      if (!ok || r !== 2'b10 || regs_o !== snap) begin
        errors++; $display("FAIL err_write_%h: got ok=%0d resp=%b regs_changed=%0d expected 1 10 0", bad_addr[i], ok, r, regs_o !== snap);
      end
    end
    do_write(32'h08, 32'h0, 4'h0, r, ok);
    checks++;
    if (!ok || r !== 2'b00 || regs_o !== snap) begin
      errors++; $display("FAIL err_zero_strb: got ok=%0d resp=%b regs_changed=%0d expected 1 00 0", ok, r, regs_o !== snap);
    end
    do_read(32'h40, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL err_read_40: got ok=%0d data=%h resp=%b expected 1 0 10", ok, d, r);
    end
    do_read(32'h3C, d, r, ok);
    checks++;
    if (!ok || d !== STAT15 || r !== 2'b00) begin
      errors++; $display("FAIL err_read_ro: got ok=%0d data=%h resp=%b expected 1 %h 00", ok, d, r, STAT15);
    end
  endtask

  task automatic test_backpressure();
    bit stable;
    @(negedge ACLK);
    AWADDR = 32'h0C; AWVALID = 1'b1; WDATA = 32'h0BADF00D; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    stable = 1;
    for (int c = 0; c < 5; c++) begin
      if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0 || WREADY !== 1'b0) stable = 0;
      @(negedge ACLK);
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL bp_write_stable: got bvalid=%b bresp=%b awready=%b expected 1 00 0", BVALID, BRESP, AWREADY);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    checks++;
    if (BVALID !== 1'b0) begin
      errors++; $display("FAIL bp_write_release: got bvalid=%b expected 0", BVALID);
    end
    ARADDR = 32'h0C; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    stable = 1;
    for (int c = 0; c < 5; c++) begin
      if (RVALID !== 1'b1 || RDATA !== 32'h0BADF00D || RRESP !== 2'b00 || ARREADY !== 1'b0) stable = 0;
      @(negedge ACLK);
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL bp_read_stable: got rvalid=%b rdata=%h arready=%b expected 1 0badf00d 0", RVALID, RDATA, ARREADY);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      errors++; $display("FAIL bp_read_release: got rvalid=%b arready=%b expected 0 1", RVALID, ARREADY);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    @(negedge ACLK);
    AWADDR = 32'h10; AWVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 32'h10; ARVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'h0 || RRESP !== 2'b00) begin
      errors++; $display("FAIL collision_read_old: got rvalid=%b rdata=%h expected 1 0", RVALID, RDATA);
    end
    checks++;
    if (BVALID !== 1'b1 || regs_o[4*32 +: 32] !== 32'h12345678) begin
      errors++; $display("FAIL collision_write: got bvalid=%b reg4=%h expected 1 12345678", BVALID, regs_o[4*32 +: 32]);
    end
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    do_read(32'h10, d, r, ok);
    checks++;
    if (!ok || d !== 32'h12345678 || r !== 2'b00) begin
      errors++; $display("FAIL collision_read_new: got ok=%0d data=%h resp=%b expected 1 12345678 00", ok, d, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, exp;
    logic [1:0] r;
    bit ok;
    for (int i = 5; i < 8; i++) begin
      do_write(32'(i * 4), 32'h0101_0101 * 32'(i), 4'hF, r, ok);
      checks++;
      if (!ok || r !== 2'b00) begin
        errors++; $display("FAIL b2b_write_%0d: got ok=%0d resp=%b expected 1 00", i, ok, r);
      end
    end
    for (int i = 5; i < 8; i++) begin
      exp = 32'h0101_0101 * 32'(i);
      do_read(32'(i * 4), d, r, ok);
      checks++;
      if (!ok || d !== exp || r !== 2'b00) begin
        errors++; $display("FAIL b2b_read_%0d: got ok=%0d data=%h resp=%b expected 1 %h 00", i, ok, d, r, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge ACLK);
    AWADDR = 32'h14; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    checks++;
    if (AWREADY !== 1'b0 || WREADY !== 1'b1) begin
      errors++; $display("FAIL mid_aw_latched: got awready=%b wready=%b expected 0 1", AWREADY, WREADY);
    end
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1 || regs_o !== '0) begin
      errors++; $display("FAIL mid_reset_state: got bvalid=%b awready=%b wready=%b regs_zero=%0d expected 0 1 1 1", BVALID, AWREADY, WREADY, regs_o === '0);
    end
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    repeat (2) @(negedge ACLK);
    checks++;
    if (BVALID !== 1'b0 || regs_o !== '0) begin
      errors++; $display("FAIL mid_aw_dropped: got bvalid=%b regs_zero=%0d expected 0 1", BVALID, regs_o === '0);
    end
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) hw_status_i[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
    hw_status_i[15*32 +: 32] = STAT15;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_errors();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
